// File: rtl/fb_pkg.sv
// Shared frame-buffer types: geometry, packed write record, grant encoding and
// the {y,x} address helper used by both the write FIFO and the arbiter.
package fb_pkg;

    localparam int FB_W  = 256;
    localparam int FB_H  = 240;
    localparam int PIX_W = 6;

    typedef logic [15:0] fb_addr_t;

    typedef struct packed {
        logic [7:0]       y;
        logic [7:0]       x;
        logic [PIX_W-1:0] data;
    } fb_wr_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    // Row-major with a 256-wide row, so the address is a plain concatenation.
    function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [7:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO of pending PPU pixel writes. Push is ignored when full and pop
// is ignored when empty; a push and pop in the same cycle leave the level unchanged.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        push,
    input  logic        pop,
    input  fb_wr_t      din,
    output fb_wr_t      dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    fb_wr_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA scan-out reads always win the RAM, PPU
// pixel writes are queued and drained in any cycle without a read.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             ppu_wr_valid,
    output logic             ppu_wr_ready,
    input  logic [7:0]       ppu_wr_x,
    input  logic [7:0]       ppu_wr_y,
    input  logic [PIX_W-1:0] ppu_wr_data,
    input  logic             vga_rd_valid,
    input  logic [7:0]       vga_rd_x,
    input  logic [7:0]       vga_rd_y,
    output logic [PIX_W-1:0] vga_rd_data,
    output logic             vga_rd_dvalid,
    output logic [15:0]      ram_addr,
    output logic             ram_we,
    output logic [PIX_W-1:0] ram_wdata,
    input  logic [PIX_W-1:0] ram_rdata,
    output logic [LVL_W-1:0] fifo_level,
    output logic [1:0]       gnt,
    output logic             wr_stall_seen,
    input  logic             clr_status
);

    // PPU handshake: a write transfers in a cycle where ppu_wr_valid && ppu_wr_ready;
    // ready depends only on registered FIFO state, never on valid.
    fb_wr_t wr_in;
    fb_wr_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;
    gnt_e   gnt_sel;
    logic   rd_pend;

    assign wr_in        = '{y: ppu_wr_y, x: ppu_wr_x, data: ppu_wr_data};
    assign ppu_wr_ready = !fifo_full;
    assign push         = ppu_wr_valid && ppu_wr_ready;
    assign pop          = !vga_rd_valid && !fifo_empty;
    assign gnt          = gnt_sel;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .pop     (pop),
        .din     (wr_in),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Off-screen rows are still popped so a bad write cannot block the queue.
    always_comb begin
        gnt_sel   = GNT_NONE;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (vga_rd_valid) begin
            gnt_sel  = GNT_RD;
            ram_addr = fb_addr(vga_rd_x, vga_rd_y);
        end else if (!fifo_empty) begin
            gnt_sel   = GNT_WR;
            ram_addr  = fb_addr(head.x, head.y);
            ram_wdata = head.data;
            ram_we    = (head.y < 8'(FB_H));
        end
    end

    // Request in N, RAM data in N+1, registered result visible in N+2.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_pend       <= 1'b0;
            vga_rd_dvalid <= 1'b0;
            vga_rd_data   <= '0;
        end else begin
            rd_pend       <= vga_rd_valid;
            vga_rd_dvalid <= rd_pend;
            if (rd_pend) begin
                vga_rd_data <= ram_rdata;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_stall_seen <= 1'b0;
        end else if (ppu_wr_valid && !ppu_wr_ready) begin
            wr_stall_seen <= 1'b1;
        end else if (clr_status) begin
            wr_stall_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: cycle vector table plus hand sequences for
// FIFO fill/stall/drain, read latency and asynchronous reset.
module tb_fb_port_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic        ppu_wr_valid;
    logic        ppu_wr_ready;
    logic [7:0]  ppu_wr_x;
    logic [7:0]  ppu_wr_y;
    logic [5:0]  ppu_wr_data;
    logic        vga_rd_valid;
    logic [7:0]  vga_rd_x;
    logic [7:0]  vga_rd_y;
    logic [5:0]  vga_rd_data;
    logic        vga_rd_dvalid;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [5:0]  ram_wdata;
    logic [5:0]  ram_rdata;
    logic [4:0]  fifo_level;
    logic [1:0]  gnt;
    logic        wr_stall_seen;
    logic        clr_status;

    int tests_run;
    int tests_failed;

    logic        poke_en;
    logic [15:0] poke_addr;
    logic [5:0]  poke_data;
    logic [5:0]  ram_mem [65536];

    logic [21:0] exp_q[$];

    typedef struct {
        logic        rd_v;
        logic [7:0]  rd_x;
        logic [7:0]  rd_y;
        logic        wr_v;
        logic [7:0]  wr_x;
        logic [7:0]  wr_y;
        logic [5:0]  wr_d;
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [15:0] e_addr;
        logic [5:0]  e_wdata;
        logic [4:0]  e_level;
    } vec_t;

    vec_t vecs[14];

    fb_port_arbiter dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ppu_wr_valid  (ppu_wr_valid),
        .ppu_wr_ready  (ppu_wr_ready),
        .ppu_wr_x      (ppu_wr_x),
        .ppu_wr_y      (ppu_wr_y),
        .ppu_wr_data   (ppu_wr_data),
        .vga_rd_valid  (vga_rd_valid),
        .vga_rd_x      (vga_rd_x),
        .vga_rd_y      (vga_rd_y),
        .vga_rd_data   (vga_rd_data),
        .vga_rd_dvalid (vga_rd_dvalid),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .fifo_level    (fifo_level),
        .gnt           (gnt),
        .wr_stall_seen (wr_stall_seen),
        .clr_status    (clr_status)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Synchronous single-port RAM, 1-cycle read latency
    always @(posedge Clk) begin
        if (poke_en) begin
            ram_mem[poke_addr] <= poke_data;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [7:0] rx, input logic [7:0] ry,
                         input logic wv, input logic [7:0] wx, input logic [7:0] wy,
                         input logic [5:0] wd);
        vga_rd_valid = rv;
        vga_rd_x     = rx;
        vga_rd_y     = ry;
        ppu_wr_valid = wv;
        ppu_wr_x     = wx;
        ppu_wr_y     = wy;
        ppu_wr_data  = wd;
    endtask

    function automatic vec_t mk(input logic rv, input logic [7:0] rx, input logic [7:0] ry,
                                input logic wv, input logic [7:0] wx, input logic [7:0] wy,
                                input logic [5:0] wd, input logic [1:0] eg, input logic ewe,
                                input logic [15:0] ea, input logic [5:0] ewd,
                                input logic [4:0] el);
        vec_t v;
        v.rd_v = rv; v.rd_x = rx; v.rd_y = ry;
        v.wr_v = wv; v.wr_x = wx; v.wr_y = wy; v.wr_d = wd;
        v.e_gnt = eg; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd; v.e_level = el;
        return v;
    endfunction

    initial begin
        logic [5:0]  rd_exp [3];
        logic [21:0] e;
        int          we_bad;
        logic        exp_dv;

        tests_run    = 0;
        tests_failed = 0;
        poke_en      = 1'b0;
        poke_addr    = '0;
        poke_data    = '0;
        clr_status   = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // gnt: 0 NONE, 1 RD, 2 WR
        vecs[0]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd0, 0, 16'h0000, 6'h00, 5'd0);
        vecs[1]  = mk(0, 8'h00, 8'h00, 1, 8'h05, 8'h03, 6'h2A, 2'd0, 0, 16'h0000, 6'h00, 5'd0);
        vecs[2]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd2, 1, 16'h0305, 6'h2A, 5'd1);
        vecs[3]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd0, 0, 16'h0000, 6'h00, 5'd0);
        vecs[4]  = mk(0, 8'h00, 8'h00, 1, 8'h01, 8'hF0, 6'h07, 2'd0, 0, 16'h0000, 6'h00, 5'd0);
        vecs[5]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd2, 0, 16'hF001, 6'h07, 5'd1);
        vecs[6]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd0, 0, 16'h0000, 6'h00, 5'd0);
        vecs[7]  = mk(1, 8'h10, 8'h20, 1, 8'h02, 8'h02, 6'h15, 2'd1, 0, 16'h2010, 6'h00, 5'd0);
        vecs[8]  = mk(1, 8'h11, 8'h20, 0, 8'h00, 8'h00, 6'h00, 2'd1, 0, 16'h2011, 6'h00, 5'd1);
        vecs[9]  = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd2, 1, 16'h0202, 6'h15, 5'd1);
        vecs[10] = mk(0, 8'h00, 8'h00, 1, 8'h03, 8'h04, 6'h3F, 2'd0, 0, 16'h0000, 6'h00, 5'd0);
        vecs[11] = mk(0, 8'h00, 8'h00, 1, 8'h04, 8'h04, 6'h01, 2'd2, 1, 16'h0403, 6'h3F, 5'd1);
        vecs[12] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd2, 1, 16'h0404, 6'h01, 5'd1);
        vecs[13] = mk(0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 6'h00, 2'd0, 0, 16'h0000, 6'h00, 5'd0);

        // Reset state
        Reset_n = 1'b0;
        @(negedge Clk);
        check("rst_gnt",    32'(gnt), 32'd0);
        check("rst_we",     32'(ram_we), 32'd0);
        check("rst_addr",   32'(ram_addr), 32'd0);
        check("rst_wdata",  32'(ram_wdata), 32'd0);
        check("rst_ready",  32'(ppu_wr_ready), 32'd1);
        check("rst_level",  32'(fifo_level), 32'd0);
        check("rst_dvalid", 32'(vga_rd_dvalid), 32'd0);
        check("rst_rdata",  32'(vga_rd_data), 32'd0);
        check("rst_stall",  32'(wr_stall_seen), 32'd0);
        repeat (2) @(posedge Clk);
        #3 Reset_n = 1'b1;
        next_cycle();

        // Table-driven single-cycle vectors
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rd_v, vecs[i].rd_x, vecs[i].rd_y,
                  vecs[i].wr_v, vecs[i].wr_x, vecs[i].wr_y, vecs[i].wr_d);
            @(negedge Clk);
            check($sformatf("vec%0d_gnt", i),   32'(gnt), 32'(vecs[i].e_gnt));
            check($sformatf("vec%0d_we", i),    32'(ram_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].e_level));
            check($sformatf("vec%0d_ready", i), 32'(ppu_wr_ready), 32'd1);
            if (vecs[i].e_gnt != 2'd0)
                check($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            if (vecs[i].e_gnt == 2'd2)
                check($sformatf("vec%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wdata));
            next_cycle();
        end

        // Read latency and back-to-back reads
        rd_exp[0] = 6'h11;
        rd_exp[1] = 6'h22;
        rd_exp[2] = 6'h33;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            poke_en   = 1'b1;
            poke_addr = {8'hEF, 8'(8'hFF - k)};
            poke_data = rd_exp[k];
            next_cycle();
        end
        poke_en = 1'b0;
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            drive(k < 3, 8'(8'hFF - k), 8'hEF, 0, 0, 0, 0);
            @(negedge Clk);
            exp_dv = (k >= 2 && k < 5);
            check($sformatf("rd%0d_dvalid", k), 32'(vga_rd_dvalid), 32'(exp_dv));
            if (exp_dv)
                check($sformatf("rd%0d_data", k), 32'(vga_rd_data), 32'(rd_exp[k-2]));
            next_cycle();
        end

        // Fill under continuous reads, stall, then in-order drain
        we_bad = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 8'(k), 8'h50, k < 17, 8'(k), 8'h40, 6'(k + 1));
            @(negedge Clk);
            check($sformatf("fill%0d_ready", k), 32'(ppu_wr_ready),
                  32'(exp_q.size() < 16));
            if (ram_we) we_bad++;
            if (ppu_wr_valid && exp_q.size() < 16)
                exp_q.push_back({8'h40, 8'(k), 6'(k + 1)});
            next_cycle();
        end
        @(negedge Clk);
        check("fill_no_we",  32'(we_bad), 32'd0);
        check("fill_stall",  32'(wr_stall_seen), 32'd1);
        check("fill_level",  32'(fifo_level), 32'd16);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            e = exp_q.pop_front();
            check($sformatf("drain%0d_gnt", k),   32'(gnt), 32'd2);
            check($sformatf("drain%0d_we", k),    32'(ram_we), 32'd1);
            check($sformatf("drain%0d_addr", k),  32'(ram_addr), 32'(e[21:6]));
            check($sformatf("drain%0d_wdata", k), 32'(ram_wdata), 32'(e[5:0]));
            next_cycle();
        end
        @(negedge Clk);
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_gnt",   32'(gnt), 32'd0);
        check("stall_hold",  32'(wr_stall_seen), 32'd1);
        next_cycle();
        clr_status = 1'b1;
        next_cycle();
        clr_status = 1'b0;
        @(negedge Clk);
        check("stall_clr", 32'(wr_stall_seen), 32'd0);
        next_cycle();

        // Asynchronous reset with queued writes and reads in flight
        for (int k = 0; k < 8; k++) begin
            drive(1, 8'(k), 8'h60, 1, 8'(k), 8'h61, 6'(k));
            next_cycle();
        end
        drive(1, 8'h08, 8'h60, 0, 0, 0, 0);
        #2;
        check("prerst_level",  32'(fifo_level), 32'd8);
        check("prerst_dvalid", 32'(vga_rd_dvalid), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        #1;
        check("arst_level",  32'(fifo_level), 32'd0);
        check("arst_dvalid", 32'(vga_rd_dvalid), 32'd0);
        check("arst_ready",  32'(ppu_wr_ready), 32'd1);
        repeat (2) @(posedge Clk);
        #3 Reset_n = 1'b1;
        next_cycle();
        drive(0, 0, 0, 1, 8'h09, 8'h09, 6'h09);
        @(negedge Clk);
        check("post_ready", 32'(ppu_wr_ready), 32'd1);
        check("post_level", 32'(fifo_level), 32'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        check("post_gnt",   32'(gnt), 32'd2);
        check("post_we",    32'(ram_we), 32'd1);
        check("post_addr",  32'(ram_addr), 32'h0909);
        check("post_wdata", 32'(ram_wdata), 32'h09);
        check("post_level1", 32'(fifo_level), 32'd1);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
